// File: rtl/hazard_pkg.sv
// Shared encodings for the forwarding/hazard unit: operand mux selects and
// load-use stall FSM states.
package hazard_pkg;

    // Operand mux select driven to the EX stage for each source port.
    localparam logic [1:0] FWD_RF    = 2'b00;  // value read from the register file
    localparam logic [1:0] FWD_EXMEM = 2'b10;  // ALU result sitting in EX/MEM
    localparam logic [1:0] FWD_MEMWB = 2'b01;  // writeback value sitting in MEM/WB

    // Width of the remaining-stall down-counter; holds up to LOAD_LAT-2 = 6.
    localparam int CNT_W = 3;

    // Load-use stall FSM.
    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hazState_t;

endpackage

// File: rtl/fwd_port_sel.sv
// Per-source-port comparator: picks the EX-stage operand mux select and flags
// a load-use collision between this ID-stage source and the load in EX.
module fwd_port_sel
    import hazard_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] idExSrc,
    input  logic              exMemRegWrite,
    input  logic              exMemMemRead,
    input  logic [ADDR_W-1:0] exMemRd,
    input  logic              memWbRegWrite,
    input  logic [ADDR_W-1:0] memWbRd,
    input  logic [ADDR_W-1:0] ifIdSrc,
    input  logic              ifIdSrcValid,
    input  logic [ADDR_W-1:0] idExRd,
    output logic [1:0]        fwdSel,
    output logic              loadUseHit
);

    logic exMemHit;
    logic memWbHit;

    // A load in EX/MEM has no data yet, so it never forwards from there;
    // register 0 is hardwired and never forwarded from either stage.
    assign exMemHit = exMemRegWrite && !exMemMemRead &&
                      (exMemRd != '0) && (exMemRd == idExSrc);
    assign memWbHit = memWbRegWrite && (memWbRd != '0) && (memWbRd == idExSrc);

    // Youngest producer wins: EX/MEM is checked before MEM/WB.
    always_comb begin
        fwdSel = FWD_RF;
        if (exMemHit) begin
            fwdSel = FWD_EXMEM;
        end else if (memWbHit) begin
            fwdSel = FWD_MEMWB;
        end
    end

    // The register-0 and MemRead qualification is applied once at the top level.
    assign loadUseHit = ifIdSrcValid && (ifIdSrc == idExRd);

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding select generation for every EX-stage source operand plus the
// load-use stall controller (Stall/Bubble for LOAD_LAT cycles) with a
// saturating stall-cycle counter.
module forward_hazard_unit
    import hazard_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_SRC*ADDR_W-1:0] IF_ID_Src,
    input  logic [NUM_SRC-1:0]        IF_ID_SrcValid,
    input  logic [NUM_SRC*ADDR_W-1:0] ID_EX_Src,
    input  logic                      ID_EX_MemRead,
    input  logic [ADDR_W-1:0]         ID_EX_RegisterRd,
    input  logic                      EX_MEM_RegWrite,
    input  logic                      EX_MEM_MemRead,
    input  logic [ADDR_W-1:0]         EX_MEM_RegisterRd,
    input  logic                      MEM_WB_RegWrite,
    input  logic [ADDR_W-1:0]         MEM_WB_RegisterRd,
    output logic [2*NUM_SRC-1:0]      Forward,
    output logic                      Stall,
    output logic                      Bubble,
    output logic [15:0]               StallCount
);

    // The first stall cycle is issued from IDLE, so STALL covers the remaining
    // LOAD_LAT-1 cycles: counting down from LOAD_LAT-2 to 0 inclusive.
    localparam logic [CNT_W-1:0] CNT_INIT =
        (LOAD_LAT > 1) ? CNT_W'(LOAD_LAT - 2) : '0;

    logic [NUM_SRC-1:0] loadUseHit;
    logic               hazard;
    hazState_t          state;
    hazState_t          stateNext;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cntNext;
    logic               stallInt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_port
            fwd_port_sel #(
                .ADDR_W(ADDR_W)
            ) u_sel (
                .idExSrc      (ID_EX_Src[gi*ADDR_W +: ADDR_W]),
                .exMemRegWrite(EX_MEM_RegWrite),
                .exMemMemRead (EX_MEM_MemRead),
                .exMemRd      (EX_MEM_RegisterRd),
                .memWbRegWrite(MEM_WB_RegWrite),
                .memWbRd      (MEM_WB_RegisterRd),
                .ifIdSrc      (IF_ID_Src[gi*ADDR_W +: ADDR_W]),
                .ifIdSrcValid (IF_ID_SrcValid[gi]),
                .idExRd       (ID_EX_RegisterRd),
                .fwdSel       (Forward[2*gi +: 2]),
                .loadUseHit   (loadUseHit[gi])
            );
        end
    endgenerate

    assign hazard = ID_EX_MemRead && (ID_EX_RegisterRd != '0) && (|loadUseHit);

    // State and remaining-stall counter; reset aborts any stall in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Next-state and stall decode; flush overrides everything.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        stallInt  = 1'b0;
        case (state)
            IDLE: begin
                stallInt = hazard && !flush;
                if (hazard && !flush && (LOAD_LAT > 1)) begin
                    stateNext = STALL;
                    cntNext   = CNT_INIT;
                end
            end
            STALL: begin
                stallInt = !flush;
                if (flush) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else if (cnt == '0) begin
                    stateNext = IDLE;
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    assign Stall  = stallInt;
    assign Bubble = stallInt;

    // Stall-cycle statistic, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            StallCount <= '0;
        end else if (stallInt && (StallCount != 16'hFFFF)) begin
            StallCount <= StallCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit: two instances (LOAD_LAT=3 and 4)
// driven by the same stimulus, checked against hand-computed values.
module tb_forward_hazard_unit;

    localparam int ADDR_W  = 5;
    localparam int NUM_SRC = 2;

    logic                      clk;
    logic                      reset;
    logic                      flush;
    logic [NUM_SRC*ADDR_W-1:0] ifIdSrc;
    logic [NUM_SRC-1:0]        ifIdSrcValid;
    logic [NUM_SRC*ADDR_W-1:0] idExSrc;
    logic                      idExMemRead;
    logic [ADDR_W-1:0]         idExRd;
    logic                      exMemRegWrite;
    logic                      exMemMemRead;
    logic [ADDR_W-1:0]         exMemRd;
    logic                      memWbRegWrite;
    logic [ADDR_W-1:0]         memWbRd;

    logic [2*NUM_SRC-1:0] fwd3, fwd4;
    logic                 stall3, stall4, bubble3, bubble4;
    logic [15:0]          cnt3, cnt4;

    int nCompared   = 0;
    int nMismatched = 0;

    forward_hazard_unit #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .LOAD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .flush(flush),
        .IF_ID_Src(ifIdSrc), .IF_ID_SrcValid(ifIdSrcValid), .ID_EX_Src(idExSrc),
        .ID_EX_MemRead(idExMemRead), .ID_EX_RegisterRd(idExRd),
        .EX_MEM_RegWrite(exMemRegWrite), .EX_MEM_MemRead(exMemMemRead),
        .EX_MEM_RegisterRd(exMemRd), .MEM_WB_RegWrite(memWbRegWrite),
        .MEM_WB_RegisterRd(memWbRd), .Forward(fwd3), .Stall(stall3),
        .Bubble(bubble3), .StallCount(cnt3)
    );

    forward_hazard_unit #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .LOAD_LAT(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush),
        .IF_ID_Src(ifIdSrc), .IF_ID_SrcValid(ifIdSrcValid), .ID_EX_Src(idExSrc),
        .ID_EX_MemRead(idExMemRead), .ID_EX_RegisterRd(idExRd),
        .EX_MEM_RegWrite(exMemRegWrite), .EX_MEM_MemRead(exMemMemRead),
        .EX_MEM_RegisterRd(exMemRd), .MEM_WB_RegWrite(memWbRegWrite),
        .MEM_WB_RegisterRd(memWbRd), .Forward(fwd4), .Stall(stall4),
        .Bubble(bubble4), .StallCount(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock, leaving us 1 time unit past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        flush         = 1'b0;
        ifIdSrc       = '0;
        ifIdSrcValid  = '0;
        idExSrc       = '0;
        idExMemRead   = 1'b0;
        idExRd        = '0;
        exMemRegWrite = 1'b0;
        exMemMemRead  = 1'b0;
        exMemRd       = '0;
        memWbRegWrite = 1'b0;
        memWbRd       = '0;
    endtask

    task automatic doReset();
        clearInputs();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
    endtask

    // Load in EX writing r7, ID instruction reads r7 on port 1 (valid).
    task automatic driveLoadUse();
        idExMemRead  = 1'b1;
        idExRd       = 5'd7;
        ifIdSrc      = {5'd7, 5'd2};
        ifIdSrcValid = 2'b10;
    endtask

    initial begin
        clearInputs();
        reset = 1'b0;
        tick();
        tick();
        #1;
        reset = 1'b1;
        #1;

        // Reset state
        chk("rst_cnt3",  cnt3,    0);
        chk("rst_stall", stall3,  0);
        chk("rst_bub",   bubble4, 0);

        // Both ports match EX/MEM and MEM/WB -> EX/MEM wins on both
        exMemRegWrite = 1'b1; exMemRd = 5'd5;
        memWbRegWrite = 1'b1; memWbRd = 5'd5;
        idExSrc = {5'd5, 5'd5};
        #1 chk("fwd_prio", fwd3, 4'b1010);

        // EX/MEM Rd=0 ignored, MEM/WB r3 forwards to port 0, port 1 reads r0
        exMemRd = 5'd0; memWbRd = 5'd3;
        idExSrc = {5'd0, 5'd3};
        #1 chk("fwd_rd0", fwd3, 4'b0001);

        // MEM/WB writing r0 never forwards
        memWbRd = 5'd0; idExSrc = {5'd0, 5'd0};
        #1 chk("fwd_wb0", fwd3, 4'b0000);

        // Load in EX/MEM cannot forward; falls back to MEM/WB
        exMemMemRead = 1'b1; exMemRd = 5'd9;
        memWbRd = 5'd9; idExSrc = {5'd1, 5'd9};
        #1 chk("fwd_ldmem", fwd3, 4'b0001);

        // EX/MEM hit on port 1 only, MEM/WB write disabled
        exMemMemRead = 1'b0; exMemRd = 5'd12; memWbRegWrite = 1'b0;
        idExSrc = {5'd12, 5'd9};
        #1 chk("fwd_port1", fwd4, 4'b1000);
        clearInputs();

        // Load-use with LOAD_LAT=3 and 4
        tick();
        doReset();
        driveLoadUse();
        #1;
        chk("lu_c1_s3", stall3, 1);
        chk("lu_c1_b4", bubble4, 1);
        tick();
        idExMemRead = 1'b0;
        #1 chk("lu_c2_s3", stall3, 1);
        tick();
        #1 chk("lu_c3_s3", stall3, 1);
        tick();
        #1;
        chk("lu_c4_s3", stall3, 0);
        chk("lu_cnt3",  cnt3,   3);
        chk("lu_c4_s4", stall4, 1);
        tick();
        #1;
        chk("lu_c5_s4", stall4, 0);
        chk("lu_cnt4",  cnt4,   4);

        // Matching address on an unused port: no hazard
        doReset();
        driveLoadUse();
        ifIdSrcValid = 2'b01;
        #1 chk("nv_stall", stall3, 0);
        tick();
        #1 chk("nv_cnt", cnt3, 0);

        // Load writing r0: no hazard
        driveLoadUse();
        idExRd = 5'd0; ifIdSrc = {5'd0, 5'd0}; ifIdSrcValid = 2'b11;
        #1 chk("r0_stall", stall4, 0);

        // Flush in second stall cycle of LOAD_LAT=4
        doReset();
        driveLoadUse();
        #1 chk("fl_c1", stall4, 1);
        tick();
        idExMemRead = 1'b0;
        flush = 1'b1;
        #1 chk("fl_c2", stall4, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_c3",  stall4, 0);
        chk("fl_cnt", cnt4,   1);

        // Reset asserted mid-stall (LOAD_LAT=3)
        doReset();
        driveLoadUse();
        #1;
        tick();
        idExMemRead = 1'b0;
        #1 chk("rm_c2", stall3, 1);
        reset = 1'b0;
        #1;
        chk("rm_cnt_in",   cnt3,   0);
        chk("rm_stall_in", stall3, 0);
        reset = 1'b1;
        tick();
        #1;
        chk("rm_stall_out", stall3, 0);
        chk("rm_cnt_out",   cnt3,   0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
